// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO push arbiter.
package fifo_arb_pkg;

   typedef enum logic {IDLE, OWN} arb_state_e;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned bcnt_w(input int unsigned burst_max);
      return (burst_max <= 1) ? 1 : $clog2(burst_max + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first unmasked request at or after i_start, wrapping.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]              i_req,
   input  logic [idx_w(NREQ)-1:0]       i_start,
   input  logic [NREQ-1:0]              i_mask,
   output logic [idx_w(NREQ)-1:0]       o_idx,
   output logic                         o_valid
);

   localparam int unsigned IDXW = idx_w(NREQ);

   logic [NREQ-1:0] w_cand;

   always_comb begin
      w_cand  = i_req & ~i_mask;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         int unsigned p;
         p = (32'(i_start) + k) % NREQ;
         if (!o_valid && w_cand[p]) begin
            o_valid = 1'b1;
            o_idx   = IDXW'(p);
         end
      end
   end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing one FIFO push port among NREQ requesters with bounded bursts.
module fifo_push_arb
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   data,
   output logic [NREQ-1:0]         ack,
   output logic [NREQ-1:0]         gnt,
   output logic                    fifo_push_req,
   output logic [WIDTH-1:0]        fifo_data_in,
   input  logic                    fifo_push_ack
);

   localparam int unsigned IDXW  = idx_w(NREQ);
   localparam int unsigned BCNTW = bcnt_w(BURST_MAX);
   localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NREQ - 1);
   localparam logic [BCNTW-1:0] BURST_END = BCNTW'(BURST_MAX - 1);

   arb_state_e        r_st;
   logic [IDXW-1:0]   r_owner;
   logic [IDXW-1:0]   r_rr_ptr;
   logic [BCNTW-1:0]  r_bcnt;
   logic [NREQ-1:0]   r_gnt;

   logic              w_own;
   logic              w_owner_req;
   logic              w_xfer;
   logic              w_burst_end;
   logic [IDXW-1:0]   w_owner_nxt;
   logic [NREQ-1:0]   w_owner_oh;
   logic [NREQ-1:0]   w_pick_oh;
   logic [IDXW-1:0]   w_pick_start;
   logic [NREQ-1:0]   w_pick_mask;
   logic [IDXW-1:0]   w_pick_idx;
   logic              w_pick_valid;
   logic [IDXW-1:0]   w_sel;

   assign w_own        = (r_st == OWN);
   assign w_owner_req  = req[r_owner];
   assign w_xfer       = w_own & w_owner_req & fifo_push_ack;
   assign w_burst_end  = (r_bcnt == BURST_END);
   assign w_owner_nxt  = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
   assign w_sel        = w_own ? r_owner : '0;

   // While owning, the picker always scans from owner+1, which is the rotated rr_ptr.
   assign w_pick_start = w_own ? w_owner_nxt : r_rr_ptr;
   assign w_pick_mask  = (w_own && ((req & ~w_owner_oh) != '0)) ? w_owner_oh : '0;

   always_comb begin
      w_owner_oh   = '0;
      w_pick_oh    = '0;
      fifo_data_in = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_owner_oh[i] = (IDXW'(i) == r_owner);
         w_pick_oh[i]  = (IDXW'(i) == w_pick_idx);
         if (IDXW'(i) == w_sel) begin
            fifo_data_in = data[i*WIDTH +: WIDTH];
         end
      end
   end

   rr_pick #(.NREQ(NREQ)) u_pick (
      .i_req   (req),
      .i_start (w_pick_start),
      .i_mask  (w_pick_mask),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   assign gnt           = reset ? '0 : r_gnt;
   assign fifo_push_req = w_own & w_owner_req & ~reset;
   assign ack           = (w_xfer && !reset) ? w_owner_oh : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_st     <= IDLE;
         r_owner  <= '0;
         r_rr_ptr <= '0;
         r_bcnt   <= '0;
         r_gnt    <= '0;
      end else begin
         case (r_st)
            IDLE: begin
               if (|req) begin
                  r_st    <= OWN;
                  r_owner <= w_pick_idx;
                  r_gnt   <= w_pick_oh;
                  r_bcnt  <= '0;
               end
            end
            OWN: begin
               if (w_xfer && !w_burst_end) begin
                  r_bcnt <= r_bcnt + 1'b1;
               end else if (w_xfer || !w_owner_req) begin
                  // Burst end or release: rotate and hand over without a bubble.
                  r_rr_ptr <= w_owner_nxt;
                  r_bcnt   <= '0;
                  if (w_pick_valid) begin
                     r_owner <= w_pick_idx;
                     r_gnt   <= w_pick_oh;
                  end else begin
                     r_st  <= IDLE;
                     r_gnt <= '0;
                  end
               end
            end
            default: r_st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench: vector table, directed corner sequences, random run vs reference model.
module tb_fifo_push_arb;

   localparam int NREQ      = 4;
   localparam int WIDTH     = 32;
   localparam int BURST_MAX = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       ack;
   logic [NREQ-1:0]       gnt;
   logic                  fifo_push_req;
   logic [WIDTH-1:0]      fifo_data_in;
   logic                  fifo_push_ack;

   logic [WIDTH-1:0]      dval [NREQ];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   always_comb begin
      data = '0;
      for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = dval[i];
   end

   fifo_push_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .data          (data),
      .ack           (ack),
      .gnt           (gnt),
      .fifo_push_req (fifo_push_req),
      .fifo_data_in  (fifo_data_in),
      .fifo_push_ack (fifo_push_ack)
   );

   typedef struct {
      logic            rst;
      logic [NREQ-1:0] rq;
      logic            fa;
      logic [NREQ-1:0] gnt;
      logic [NREQ-1:0] ack;
      logic            preq;
      int              sel;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic chk_out(input string nm, input logic [NREQ-1:0] g, input logic [NREQ-1:0] a,
                          input logic p);
      chk({nm, ".gnt"}, 64'(gnt), 64'(g));
      chk({nm, ".ack"}, 64'(ack), 64'(a));
      chk({nm, ".preq"}, 64'(fifo_push_req), 64'(p));
   endtask

   // Inputs are applied 1 time unit after a rising edge; outputs are sampled 4 units later.
   task automatic drive(input logic r, input logic [NREQ-1:0] rq, input logic fa);
      reset         = r;
      req           = rq;
      fifo_push_ack = fa;
      #4;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   function automatic int first_from(input logic [NREQ-1:0] v, input int s);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(s + k) % NREQ]) return (s + k) % NREQ;
      end
      return -1;
   endfunction

   // Reference model: owner (-1 when idle), rotation pointer, accepted pushes in the current grant.
   int m_owner, m_rr, m_cnt;

   task automatic model_update(input logic r, input logic [NREQ-1:0] rq, input logic fa);
      logic [NREQ-1:0] others;
      if (r) begin
         m_owner = -1; m_rr = 0; m_cnt = 0;
      end else if (m_owner < 0) begin
         if (rq != '0) begin
            m_owner = first_from(rq, m_rr);
            m_cnt   = 0;
         end
      end else if (rq[m_owner] && fa) begin
         m_cnt++;
         if (m_cnt == BURST_MAX) begin
            m_rr   = (m_owner + 1) % NREQ;
            m_cnt  = 0;
            others = rq & ~(NREQ'(1) << m_owner);
            if (others != '0) m_owner = first_from(others, m_rr);
         end
      end else if (!rq[m_owner]) begin
         m_rr    = (m_owner + 1) % NREQ;
         m_cnt   = 0;
         m_owner = first_from(rq, m_rr);
      end
   endtask

   initial begin
      logic [NREQ-1:0] rq_r;
      logic            rst_r, fa_r;
      logic [NREQ-1:0] eg, ea;
      logic            ep;

      for (int i = 0; i < NREQ; i++) dval[i] = 32'hA000_0000 + 32'(i);
      reset = 1'b1; req = '0; fifo_push_ack = 1'b1;
      adv();

      // Reset hold, release, then four full bursts rotating 0..3 and back to 0.
      tbl[0] = '{1'b1, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, -1};
      tbl[1] = '{1'b1, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, -1};
      tbl[2] = '{1'b0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 0};
      for (int k = 0; k < 16; k++)
         tbl[3+k] = '{1'b0, 4'hF, 1'b1, NREQ'(1) << (k/4), NREQ'(1) << (k/4), 1'b1, k/4};
      tbl[19] = '{1'b0, 4'hF, 1'b1, 4'h1, 4'h1, 1'b1, 0};

      for (int v = 0; v < 20; v++) begin
         drive(tbl[v].rst, tbl[v].rq, tbl[v].fa);
         chk_out($sformatf("vec%0d", v), tbl[v].gnt, tbl[v].ack, tbl[v].preq);
         if (tbl[v].sel >= 0)
            chk($sformatf("vec%0d.data", v), 64'(fifo_data_in), 64'(dval[tbl[v].sel]));
         adv();
      end

      // Early release: owner 1 drops after two pushes, one dead cycle, then requester 3 bursts.
      drive(1, 4'b0000, 1); adv();
      drive(0, 4'b1010, 1); chk_out("rel_idle", 4'b0000, 4'b0000, 0); adv();
      for (int k = 0; k < 2; k++) begin
         drive(0, 4'b1010, 1); chk_out("rel_own1", 4'b0010, 4'b0010, 1); adv();
      end
      drive(0, 4'b1000, 1); chk_out("rel_dead", 4'b0010, 4'b0000, 0); adv();
      for (int k = 0; k < 4; k++) begin
         drive(0, 4'b1001, 1); chk_out("rel_own3", 4'b1000, 4'b1000, 1);
         chk("rel_own3.data", 64'(fifo_data_in), 64'(dval[3])); adv();
      end
      drive(0, 4'b0001, 1); chk_out("rel_rot0", 4'b0001, 4'b0001, 1); adv();
      drive(0, 4'b0000, 1); chk_out("rel_drop", 4'b0001, 4'b0000, 0); adv();
      drive(0, 4'b0000, 1); chk_out("rel_idle2", 4'b0000, 4'b0000, 0); adv();

      // Full stall: one push, three full cycles, then the burst completes after three more.
      drive(1, 4'b0000, 1); adv();
      drive(0, 4'b0100, 1); chk_out("stall_idle", 4'b0000, 4'b0000, 0); adv();
      drive(0, 4'b0100, 1); chk_out("stall_p1", 4'b0100, 4'b0100, 1); adv();
      for (int k = 0; k < 3; k++) begin
         drive(0, 4'b0101, 0); chk_out("stall_full", 4'b0100, 4'b0000, 1); adv();
      end
      for (int k = 0; k < 3; k++) begin
         drive(0, 4'b0101, 1); chk_out("stall_resume", 4'b0100, 4'b0100, 1); adv();
      end
      drive(0, 4'b0101, 1); chk_out("stall_rot", 4'b0001, 4'b0001, 1); adv();

      // Sole requester keeps its grant across burst boundaries.
      drive(1, 4'b0000, 1); adv();
      drive(0, 4'b0100, 1); chk_out("sole_idle", 4'b0000, 4'b0000, 0); adv();
      for (int k = 0; k < 10; k++) begin
         drive(0, 4'b0100, 1); chk_out($sformatf("sole%0d", k), 4'b0100, 4'b0100, 1); adv();
      end

      // Reset during owner 3's second push; arbitration restarts at requester 0.
      drive(1, 4'b0000, 1); adv();
      drive(0, 4'b1000, 1); chk_out("rstmid_idle", 4'b0000, 4'b0000, 0); adv();
      drive(0, 4'b1000, 1); chk_out("rstmid_p1", 4'b1000, 4'b1000, 1); adv();
      drive(1, 4'b1000, 1); chk_out("rstmid_rst", 4'b0000, 4'b0000, 0); adv();
      drive(0, 4'b1001, 1); chk_out("rstmid_idle2", 4'b0000, 4'b0000, 0); adv();
      drive(0, 4'b1001, 1); chk_out("rstmid_rr0", 4'b0001, 4'b0001, 1); adv();

      // Random traffic against the reference model.
      rq_r = '0;
      model_update(1'b1, '0, 1'b1);
      for (int c = 0; c < 600; c++) begin
         rst_r = (c < 2) || ($urandom_range(0, 149) == 0);
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 5) == 0) rq_r[i] = ~rq_r[i];
         fa_r = ($urandom_range(0, 9) < 7);
         drive(rst_r, rq_r, fa_r);
         eg = '0; ea = '0; ep = 1'b0;
         if (!rst_r && m_owner >= 0) begin
            eg = NREQ'(1) << m_owner;
            ep = rq_r[m_owner];
            ea = (rq_r[m_owner] && fa_r) ? eg : '0;
         end
         chk_out($sformatf("rnd%0d", c), eg, ea, ep);
         if (!rst_r)
            chk($sformatf("rnd%0d.data", c), 64'(fifo_data_in),
                64'(dval[(m_owner < 0) ? 0 : m_owner]));
         adv();
         model_update(rst_r, rq_r, fa_r);
         for (int i = 0; i < NREQ; i++)
            if (ea[i]) dval[i] = $urandom;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
